// File: rtl/gpu_mem_cpuvram.sv
// rtl/gpu_mem_cpuvram.sv - CPU->VRAM rectangle upload: packs pixel pairs into masked 32-byte VRAM line writes.
// Optional GPU_CPUVRAM_SETMASK_EN: force bit15 of every stored pixel when set_mask_i is high.
module gpu_mem_cpuvram #(
  parameter int PIXEL_BURST = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  input  logic [15:0]  req_x_i,
  input  logic [15:0]  req_y_i,
  input  logic [15:0]  req_sizex_i,
  input  logic [15:0]  req_sizey_i,
  output logic         req_accept_o,
  input  logic         data_valid_i,
  input  logic [31:0]  data_pair_i,
  output logic         data_accept_o,
  input  logic         set_mask_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         gpu_command_o,
  input  logic         gpu_busy_i,
  output logic [1:0]   gpu_size_o,
  output logic         gpu_write_o,
  output logic [14:0]  gpu_addr_o,
  output logic [2:0]   gpu_sub_addr_o,
  output logic [15:0]  gpu_write_mask_o,
  output logic [255:0] gpu_data_out_o
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;
  state_t state_q, state_d;

  logic [15:0]  start_x_q, cur_x_q, cur_y_q, end_x_q, end_y_q;
  logic [PIXEL_BURST*16-1:0] line_q;
  logic [PIXEL_BURST-1:0]    mask_q;
  logic [14:0]  addr_q;
  logic         rect_done_q;
  logic         hold_valid_q, hold_lane_q;
  logic [31:0]  hold_q;

  logic         consume, row_end, last_pix, flush, pair_take;
  logic [15:0]  cur_x_inc, cur_y_inc, pix_raw, pix_store;

  assign cur_x_inc = cur_x_q + 16'd1;
  assign cur_y_inc = cur_y_q + 16'd1;
  assign row_end   = (cur_x_inc == end_x_q);
  assign last_pix  = row_end && (cur_y_inc >= end_y_q);
  assign consume   = (state_q == S_FILL) && (hold_valid_q || data_valid_i);
  // x[3:0]==15 also covers the 1023->0 wrap of the 10-bit VRAM column
  assign flush     = consume && ((cur_x_q[3:0] == 4'hF) || row_end);
  assign pair_take = data_valid_i && data_accept_o;
  assign pix_raw   = hold_valid_q ? (hold_lane_q ? hold_q[31:16] : hold_q[15:0])
                                  : data_pair_i[15:0];

`ifdef GPU_CPUVRAM_SETMASK_EN
  assign pix_store = {pix_raw[15] | set_mask_i, pix_raw[14:0]};
`else
  logic unused_set_mask;
  assign unused_set_mask = set_mask_i;
  assign pix_store = pix_raw;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid_i)
                 state_d = (req_sizex_i == 16'd0 || req_sizey_i == 16'd0) ? S_DONE : S_FILL;
      S_FILL:  if (flush) state_d = S_WRITE;
      S_WRITE: if (!gpu_busy_i) state_d = rect_done_q ? S_DONE : S_FILL;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_accept_o  = 1'b0;
    data_accept_o = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    gpu_command_o = 1'b0;
    case (state_q)
      S_IDLE:  begin req_accept_o = 1'b1; busy_o = 1'b0; end
      // a fresh pair is only taken if the rectangle still needs pixels after the held one
      S_FILL:  data_accept_o = !hold_valid_q || (hold_lane_q && !last_pix);
      S_WRITE: gpu_command_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: busy_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_x_q    <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      end_x_q      <= '0;
      end_y_q      <= '0;
      line_q       <= '0;
      mask_q       <= '0;
      addr_q       <= '0;
      rect_done_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_lane_q  <= 1'b0;
      hold_q       <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid_i) begin
        start_x_q   <= req_x_i;
        cur_x_q     <= req_x_i;
        cur_y_q     <= req_y_i;
        end_x_q     <= req_x_i + req_sizex_i;
        end_y_q     <= req_y_i + req_sizey_i;
        rect_done_q <= 1'b0;
      end
      if (consume) begin
        line_q[{cur_x_q[3:0], 4'd0} +: 16] <= pix_store;
        mask_q[cur_x_q[3:0]] <= 1'b1;
        addr_q      <= {cur_y_q[8:0], cur_x_q[9:4]};
        rect_done_q <= last_pix;
        if (row_end) begin
          cur_x_q <= start_x_q;
          cur_y_q <= cur_y_inc;
        end else begin
          cur_x_q <= cur_x_inc;
        end
        if (hold_valid_q) begin
          if (!hold_lane_q) begin
            if (last_pix) hold_valid_q <= 1'b0;
            else          hold_lane_q  <= 1'b1;
          end else if (pair_take) begin
            hold_q      <= data_pair_i;
            hold_lane_q <= 1'b0;
          end else begin
            hold_valid_q <= 1'b0;
          end
        end else if (!last_pix) begin
          hold_valid_q <= 1'b1;
          hold_q       <= data_pair_i;
          hold_lane_q  <= 1'b1;
        end
      end
      if (state_q == S_WRITE && !gpu_busy_i) mask_q <= '0;
    end
  end

  assign gpu_size_o       = 2'd1;
  assign gpu_write_o      = 1'b1;
  assign gpu_sub_addr_o   = 3'd0;
  assign gpu_addr_o       = addr_q;
  assign gpu_write_mask_o = mask_q;
  assign gpu_data_out_o   = line_q;

endmodule

// File: tb/tb_gpu_mem_cpuvram.sv
// tb/tb_gpu_mem_cpuvram.sv - scoreboard bench for gpu_mem_cpuvram rectangle uploads.
module tb_gpu_mem_cpuvram;
  logic         clk_i = 1'b0;
  logic         rst_i, req_valid_i, data_valid_i, set_mask_i, gpu_busy_i;
  logic [15:0]  req_x_i, req_y_i, req_sizex_i, req_sizey_i;
  logic [31:0]  data_pair_i;
  logic         req_accept_o, data_accept_o, busy_o, done_o, gpu_command_o, gpu_write_o;
  logic [1:0]   gpu_size_o;
  logic [14:0]  gpu_addr_o;
  logic [2:0]   gpu_sub_addr_o;
  logic [15:0]  gpu_write_mask_o;
  logic [255:0] gpu_data_out_o;

  always #5 clk_i = ~clk_i;

  gpu_mem_cpuvram dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_x_i(req_x_i),
    .req_y_i(req_y_i), .req_sizex_i(req_sizex_i), .req_sizey_i(req_sizey_i),
    .req_accept_o(req_accept_o), .data_valid_i(data_valid_i), .data_pair_i(data_pair_i),
    .data_accept_o(data_accept_o), .set_mask_i(set_mask_i), .busy_o(busy_o), .done_o(done_o),
    .gpu_command_o(gpu_command_o), .gpu_busy_i(gpu_busy_i), .gpu_size_o(gpu_size_o),
    .gpu_write_o(gpu_write_o), .gpu_addr_o(gpu_addr_o), .gpu_sub_addr_o(gpu_sub_addr_o),
    .gpu_write_mask_o(gpu_write_mask_o), .gpu_data_out_o(gpu_data_out_o)
  );

  typedef struct packed {
    logic [14:0]  addr;
    logic [15:0]  mask;
    logic [255:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0, n_bad = 0, done_cnt = 0, acc_cnt = 0;

  function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [255:0] lanes(input logic [15:0] m);
    logic [255:0] r = '0;
    for (int n = 0; n < 16; n++) r[16*n +: 16] = {16{m[n]}};
    return r;
  endfunction

  function automatic logic [255:0] put(input logic [255:0] d, input int n, input logic [15:0] p);
    logic [255:0] r = d;
    r[16*n +: 16] = p;
    return r;
  endfunction

  // Monitor: every consumed write command is matched against the scoreboard head
  always @(negedge clk_i) begin
    if (!rst_i) begin
      wr_t w;
      if (done_o) done_cnt++;
      if (data_valid_i && data_accept_o) acc_cnt++;
      if (gpu_command_o && !gpu_busy_i) begin
        if (exp_q.size() == 0) check("unexpected_write", 256'd1, 256'd0);
        else begin
          w = exp_q.pop_front();
          check("wr_addr", 256'(gpu_addr_o), 256'(w.addr));
          check("wr_mask", 256'(gpu_write_mask_o), 256'(w.mask));
          check("wr_data", gpu_data_out_o & lanes(w.mask), w.data & lanes(w.mask));
        end
      end
    end
  end

  task automatic send_req(input logic [15:0] x, y, sx, sy);
    req_valid_i = 1'b1; req_x_i = x; req_y_i = y; req_sizex_i = sx; req_sizey_i = sy;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_i);
      if (req_accept_o) begin
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        return;
      end
    end
    check("req_timeout", 256'd0, 256'd1);
    req_valid_i = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] p);
    data_valid_i = 1'b1; data_pair_i = p;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_i);
      if (data_accept_o) begin
        @(posedge clk_i); #1;
        data_valid_i = 1'b0;
        return;
      end
    end
    check("pair_timeout", 256'd0, 256'd1);
    data_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 500) begin
      @(negedge clk_i);
      k++;
    end
    repeat (3) @(posedge clk_i);
    #1;
    check("done_count", 256'(done_cnt), 256'(target));
  endtask

  initial begin
    logic [255:0] d;
    logic [14:0]  a0;
    logic [15:0]  m0;
    logic [255:0] d0;
    int           acc0;
    rst_i = 1'b1; req_valid_i = 1'b0; data_valid_i = 1'b0; set_mask_i = 1'b0; gpu_busy_i = 1'b0;
    req_x_i = '0; req_y_i = '0; req_sizex_i = '0; req_sizey_i = '0; data_pair_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_req_accept", 256'(req_accept_o), 256'd1);
    check("rst_busy", 256'(busy_o), 256'd0);
    check("rst_done", 256'(done_o), 256'd0);
    check("rst_cmd", 256'(gpu_command_o), 256'd0);
    check("rst_data_accept", 256'(data_accept_o), 256'd0);
    check("rst_mask", 256'(gpu_write_mask_o), 256'd0);
    check("rst_data", gpu_data_out_o, 256'd0);
    check("rst_consts", 256'({gpu_size_o, gpu_write_o, gpu_sub_addr_o}), 256'({2'd1, 1'b1, 3'd0}));
    @(posedge clk_i); #1;

    // full 16-pixel line at origin
    d = '0;
    for (int n = 0; n < 16; n++) d = put(d, n, 16'h0A00 + 16'(n));
    exp_q.push_back('{addr: 15'd0, mask: 16'hFFFF, data: d});
    send_req(16'd0, 16'd0, 16'd16, 16'd1);
    for (int i = 0; i < 8; i++) send_pair({16'h0A01 + 16'(2*i), 16'h0A00 + 16'(2*i)});
    wait_done(1);

    // partial line mid-group
    d = '0;
    d = put(d, 5, 16'h0001); d = put(d, 6, 16'h0002); d = put(d, 7, 16'h0003); d = put(d, 8, 16'h0004);
    exp_q.push_back('{addr: {9'd2, 6'd0}, mask: 16'h01E0, data: d});
    send_req(16'd5, 16'd2, 16'd4, 16'd1);
    send_pair(32'h0002_0001);
    send_pair(32'h0004_0003);
    wait_done(2);

    // group crossing and row crossing
    exp_q.push_back('{addr: 15'd0,  mask: 16'hC000, data: put(put('0, 14, 16'h2001), 15, 16'h2002)});
    exp_q.push_back('{addr: 15'd1,  mask: 16'h0003, data: put(put('0, 0, 16'h2003), 1, 16'h2004)});
    exp_q.push_back('{addr: 15'd64, mask: 16'hC000, data: put(put('0, 14, 16'h2005), 15, 16'h2006)});
    exp_q.push_back('{addr: 15'd65, mask: 16'h0003, data: put(put('0, 0, 16'h2007), 1, 16'h2008)});
    send_req(16'd14, 16'd0, 16'd4, 16'd2);
    send_pair(32'h2002_2001);
    send_pair(32'h2004_2003);
    send_pair(32'h2006_2005);
    send_pair(32'h2008_2007);
    wait_done(3);

    // odd-size rect with memory stall; surplus pairs must never be taken
    gpu_busy_i = 1'b1;
    acc0 = acc_cnt;
    exp_q.push_back('{addr: {9'd3, 6'd0}, mask: 16'h0007,
                      data: put(put(put('0, 0, 16'h0001), 1, 16'h0002), 2, 16'h0003)});
    send_req(16'd0, 16'd3, 16'd3, 16'd1);
    send_pair(32'h0002_0001);
    send_pair(32'hBEEF_0003);
    data_valid_i = 1'b1; data_pair_i = 32'hDEAD_DEAD;
    begin
      int k = 0;
      while (!gpu_command_o && k < 200) begin
        @(negedge clk_i);
        k++;
      end
    end
    check("stall_cmd_seen", 256'(gpu_command_o), 256'd1);
    a0 = gpu_addr_o; m0 = gpu_write_mask_o; d0 = gpu_data_out_o;
    repeat (5) begin
      @(negedge clk_i);
      check("stall_cmd_held", 256'(gpu_command_o), 256'd1);
      check("stall_stable", {gpu_data_out_o, gpu_addr_o, gpu_write_mask_o} == {d0, a0, m0} ? 256'd1 : 256'd0, 256'd1);
      check("stall_no_accept", 256'(data_accept_o), 256'd0);
    end
    @(posedge clk_i); #1 gpu_busy_i = 1'b0;
    wait_done(4);
    data_valid_i = 1'b0;
    check("odd_accept_count", 256'(acc_cnt - acc0), 256'd2);

    // zero width: immediate done, nothing accepted, no write
    acc0 = acc_cnt;
    data_valid_i = 1'b1; data_pair_i = 32'h7777_7777;
    send_req(16'd10, 16'd10, 16'd0, 16'd4);
    @(negedge clk_i);
    check("zero_done_pulse", 256'(done_o), 256'd1);
    wait_done(5);
    data_valid_i = 1'b0;
    check("zero_accept_count", 256'(acc_cnt - acc0), 256'd0);

    // reset during FILL drops the partial line
    send_req(16'd0, 16'd5, 16'd16, 16'd1);
    send_pair(32'h1111_1111);
    send_pair(32'h2222_2222);
    send_pair(32'h3333_3333);
    rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_req_accept", 256'(req_accept_o), 256'd1);
    check("midrst_busy", 256'(busy_o), 256'd0);
    check("midrst_cmd", 256'(gpu_command_o), 256'd0);
    check("midrst_mask", 256'(gpu_write_mask_o), 256'd0);
    repeat (4) @(posedge clk_i);
    #1;

    // set-mask bit handling on a single pixel
    set_mask_i = 1'b1;
`ifdef GPU_CPUVRAM_SETMASK_EN
    exp_q.push_back('{addr: {9'd5, 6'd0}, mask: 16'h0001, data: put('0, 0, 16'h9234)});
`else
    exp_q.push_back('{addr: {9'd5, 6'd0}, mask: 16'h0001, data: put('0, 0, 16'h1234)});
`endif
    send_req(16'd0, 16'd5, 16'd1, 16'd1);
    send_pair(32'h5555_1234);
    wait_done(6);
    set_mask_i = 1'b0;

    check("scoreboard_empty", 256'(exp_q.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
